// File: rtl/shift_out_register.sv
// rtl/shift_out_register.sv - parallel-in, serial-out shift register, LSB first, registered output
// Loads a whole frame at once; each enable presents the next bit on serial_out.

module shift_out_register #(
  parameter int unsigned Width     = 8,
  parameter logic        IdleLevel = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             enable,
  input  logic [Width-1:0] parallel_input,
  input  logic             parallel_load,
  output logic             serial_out
);

  logic [Width-1:0] sr_q, sr_d;
  logic             so_q, so_d;

  // Load beats shift, and a load never disturbs the bit already on the line.
  always_comb begin
    sr_d = sr_q;
    so_d = so_q;
    if (parallel_load) begin
      sr_d = parallel_input;
    end else if (enable) begin
      so_d = sr_q[0];
      if (Width == 1) begin
        sr_d = serial_in;
      end else begin
        sr_d = {serial_in, sr_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= {Width{IdleLevel}};
      so_q <= IdleLevel;
    end else begin
      sr_q <= sr_d;
      so_q <= so_d;
    end
  end

  assign serial_out = so_q;

endmodule

// File: tb/tb_shift_out_register.sv
// tb/tb_shift_out_register.sv - self-checking bench for shift_out_register
// Expected serial bits are queued as stimulus is driven and popped after each edge.

module tb_shift_out_register;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       enable;
  logic [7:0] parallel_input;
  logic       parallel_load;
  logic       serial_out;

  int checks;
  int errors;
  bit exp_q[$];
  bit exp;

  shift_out_register #(.Width(8), .IdleLevel(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .enable         (enable),
    .parallel_input (parallel_input),
    .parallel_load  (parallel_load),
    .serial_out     (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; returns shortly after the rising edge.
  task automatic pulse(input logic en, input logic ld, input logic [7:0] word, input logic sin);
    @(negedge clk);
    enable         = en;
    parallel_load  = ld;
    parallel_input = word;
    serial_in      = sin;
    @(posedge clk);
    #1;
    enable        = 1'b0;
    parallel_load = 1'b0;
  endtask

  task automatic test_reset();
    serial_in      = 1'b0;
    enable         = 1'b1;
    parallel_load  = 1'b1;
    parallel_input = 8'h00;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: serial_out=%b expected=1", serial_out);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: serial_out=%b expected=1", serial_out);
    end
    @(negedge clk);
    enable        = 1'b0;
    parallel_load = 1'b0;
    rst           = 1'b1;
    repeat (3) pulse(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: serial_out=%b expected=1", serial_out);
    end
  endtask

  task automatic test_serialize_overflow();
    logic [7:0] w;
    w = 8'b1010_0110;
    pulse(1'b0, 1'b1, w, 1'b1);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL load_no_change: serial_out=%b expected=1", serial_out);
    end
    for (int k = 0; k < 11; k++) begin
      exp_q.push_back((k < 8) ? w[k] : 1'b1);
      pulse(1'b1, 1'b0, 8'h00, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL serialize_bit%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
      pulse(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL serialize_hold%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
    end
    pulse(1'b0, 1'b1, w, 1'b1);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back((k < 8) ? w[k] : 1'b0);
      pulse(1'b1, 1'b0, 8'h00, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL overflow_zero_bit%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] w;
    pulse(1'b0, 1'b1, 8'h0F, 1'b1);
    exp_q.push_back(1'b1);
    pulse(1'b1, 1'b0, 8'h00, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (serial_out !== exp) begin
      errors++;
      $display("FAIL priority_first: serial_out=%b expected=%b", serial_out, exp);
    end
    w = 8'hF0;
    exp_q.push_back(1'b1);
    pulse(1'b1, 1'b1, w, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (serial_out !== exp) begin
      errors++;
      $display("FAIL priority_load_wins: serial_out=%b expected=%b", serial_out, exp);
    end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(w[k]);
      pulse(1'b1, 1'b0, 8'h00, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL priority_bit%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
    end
  endtask

  task automatic test_reload();
    pulse(1'b0, 1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b0);
      pulse(1'b1, 1'b0, 8'h00, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL reload_pre%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
    end
    pulse(1'b0, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL reload_hold: serial_out=%b expected=0", serial_out);
    end
    exp_q.push_back(1'b1);
    pulse(1'b1, 1'b0, 8'h00, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (serial_out !== exp) begin
      errors++;
      $display("FAIL reload_new: serial_out=%b expected=%b", serial_out, exp);
    end
  endtask

  task automatic test_async_reset();
    pulse(1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(1'b0);
      pulse(1'b1, 1'b0, 8'h00, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL areset_pre%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL areset_immediate: serial_out=%b expected=1", serial_out);
    end
    #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(1'b1);
      pulse(1'b1, 1'b0, 8'h00, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (serial_out !== exp) begin
        errors++;
        $display("FAIL areset_post%0d: serial_out=%b expected=%b", k, serial_out, exp);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    serial_in      = 1'b0;
    enable         = 1'b0;
    parallel_load  = 1'b0;
    parallel_input = 8'h00;
    test_reset();
    test_serialize_overflow();
    test_priority();
    test_reload();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_out_register.md
Name: shift_out_register

Overview:
- Parallel-in, serial-out shift register with a registered serial output, LSB first.
- Used as the bit serializer inside the UART transmitter: the transmitter loads a whole frame (start, data, parity, stop bits) in one cycle, then pulses `enable` once per bit period to present the next bit on the line.
- The output is registered so it holds each bit stable between enable pulses and idles at a defined level.

Parameters:
- Width, 8, number of bits held in the shift register (>= 1).
- IdleLevel, 1'b1, reset value of every internal bit and of `serial_out`; matches the idle-high UART line.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- serial_in  input  1  bit shifted into the MSB on each enable.
- enable  input  1  shift strobe, one shift per cycle it is high.
- parallel_input  input  Width  word captured on parallel_load.
- parallel_load  input  1  load strobe.
- serial_out  output  1  registered serial output.

Behaviour:
- State: internal register `sr[Width-1:0]` plus registered output bit `so`, which drives `serial_out`.
- Reset (rst=0, asynchronous, independent of clk): sr = {Width{IdleLevel}}, so = IdleLevel. Both hold while rst=0.
- Each rising clk edge with rst=1 is evaluated in priority order:
  1. parallel_load=1: sr <= parallel_input; so unchanged. Loading wins over enable when both are high; no shift happens that cycle.
  2. else enable=1: so <= sr[0]; sr <= {serial_in, sr[Width-1:1]}.
  3. else: sr and so hold.
- Latency and timing:
  - After a load, the first enable edge presents parallel_input[0] on serial_out.
  - The k-th enable presents parallel_input[k-1], for k = 1..Width.
  - serial_out changes only on enable edges; it never changes on load edges.
- Beyond Width shifts: enable k = Width+j presents the serial_in value shifted in at enable j. With serial_in tied to 1, the output stays 1 (idle/stop level).
- Load mid-shift: the remaining bits are discarded and the new word replaces sr; serial_out keeps its current bit until the next enable.
- Reset mid-operation: sr and so return to IdleLevel immediately; the loaded data is lost.
- Width=1: sr is a single bit; the shift sets sr <= serial_in and so <= old sr.
- No combinational path from any input to serial_out.

Test Plan:
- Reset: drive rst=0 with arbitrary inputs -> serial_out=1 immediately (asynchronous, before any clk edge). Release rst; with no strobes, serial_out stays 1.
- Serialize (Width=8): load 8'b1010_0110, then 8 single-cycle enable pulses separated by idle cycles, serial_in=1 -> serial_out sequence 0,1,1,0,0,1,0,1; serial_out held constant between pulses.
- Fill and overflow: after the 8 shifts above, 3 more enables with serial_in=1 -> serial_out=1,1,1. Repeat the load, shift 8 times with serial_in=0, then 8 more enables -> the second 8 outputs are all 0.
- Priority: load 8'h0F, enable once (serial_out=1). Then assert parallel_load and enable together with 8'hF0 -> serial_out remains 1 that cycle. Next enables output 0,0,0,0,1,...
- Reload mid-frame: load 8'h00, shift 3 times, load 8'hFF -> serial_out stays 0 through the load; next enable outputs 1.
- Async reset mid-frame: load 8'h00, shift twice (serial_out=0), pulse rst=0 between clock edges -> serial_out=1 at once; after release, enables output 1 (sr all ones).
